// File: rtl/audio_src_arbiter.sv
// Round-robin arbiter merging two I2S stereo receivers onto one valid/ready sample port.
// Frames are detected from each raw LRCK falling edge and held in a 1-deep slot per source.
module audio_src_arbiter #(
  parameter int unsigned DW    = 16,
  parameter int unsigned OVR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src0_lrck,
  input  logic [DW-1:0]    src0_left,
  input  logic [DW-1:0]    src0_right,
  input  logic             src1_lrck,
  input  logic [DW-1:0]    src1_left,
  input  logic [DW-1:0]    src1_right,
  input  logic [1:0]       src_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src,
  output logic [DW-1:0]    out_left,
  output logic [DW-1:0]    out_right,
  output logic [OVR_W-1:0] ovr0,
  output logic [OVR_W-1:0] ovr1
);

  logic [1:0]                  sync1_q, sync1_d;
  logic [1:0]                  sync2_q, sync2_d;
  logic [1:0]                  dly_q, dly_d;
  logic [1:0]                  pend_q, pend_d;
  logic [1:0][2*DW-1:0]        hold_q, hold_d;
  logic [1:0][OVR_W-1:0]       ovr_q, ovr_d;
  logic                        rr_q, rr_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_src_q, out_src_d;
  logic [DW-1:0]               out_left_q, out_left_d;
  logic [DW-1:0]               out_right_q, out_right_d;

  logic [1:0]                  lrck_raw;
  logic [1:0][2*DW-1:0]        src_data;
  logic [1:0]                  frame_done;
  logic [1:0]                  capture;
  logic [1:0]                  elig;
  logic [1:0]                  pop;
  logic                        slot_free;
  logic                        grant;

  assign lrck_raw    = {src1_lrck, src0_lrck};
  assign src_data[0] = {src0_left, src0_right};
  assign src_data[1] = {src1_left, src1_right};
  assign frame_done  = dly_q & ~sync2_q;
  assign capture     = frame_done & src_en;
  // A pending slot on a disabled source is never offered to the output stage.
  assign elig        = pend_q & src_en;
  assign slot_free   = ~out_valid_q | out_ready;

  always_comb begin
    grant = (elig == 2'b11) ? rr_q : elig[1];
    pop   = 2'b00;
    if (slot_free && (elig != 2'b00)) begin
      pop[grant] = 1'b1;
    end
  end

  always_comb begin
    sync1_d = lrck_raw;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
    pend_d  = pend_q;
    hold_d  = hold_q;
    ovr_d   = ovr_q;
    for (int unsigned n = 0; n < 2; n++) begin
      if (!src_en[n]) begin
        pend_d[n] = 1'b0;
      end else if (capture[n]) begin
        pend_d[n] = 1'b1;
        hold_d[n] = src_data[n];
        // Overwriting an unconsumed frame counts as an overrun; a same-cycle pop does not.
        if (pend_q[n] && !pop[n] && (ovr_q[n] != {OVR_W{1'b1}})) begin
          ovr_d[n] = ovr_q[n] + OVR_W'(1);
        end
      end else if (pop[n]) begin
        pend_d[n] = 1'b0;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    rr_d        = rr_q;
    if (slot_free) begin
      if (elig != 2'b00) begin
        out_valid_d              = 1'b1;
        out_src_d                = grant;
        {out_left_d, out_right_d} = hold_q[grant];
        rr_d                     = ~grant;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      dly_q       <= '0;
      pend_q      <= '0;
      hold_q      <= '0;
      ovr_q       <= '0;
      rr_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_src_q   <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      dly_q       <= dly_d;
      pend_q      <= pend_d;
      hold_q      <= hold_d;
      ovr_q       <= ovr_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign ovr0      = ovr_q[0];
  assign ovr1      = ovr_q[1];

endmodule

// File: doc/audio_src_arbiter.md
Name: audio_src_arbiter

Overview:
- Shares one downstream stereo sample port between two I2S stereo receivers, e.g. the ESP32 link and the on-board ADC.
- For each source, the block detects frame completion from that source's raw LRCK and captures the receiver's left/right outputs into a 1-deep holding slot.
- It then grants the output stage round-robin through a valid/ready handshake.
- Per-source enable and saturating overrun counters are exposed to the config/status register file.

Parameters:
DW, 16, sample width per channel
OVR_W, 8, width of each overrun counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
src0_lrck  in  1  raw LRCK of source 0 (bck domain, asynchronous to clk)
src0_left  in  DW  left sample from source 0 receiver
src0_right  in  DW  right sample from source 0 receiver
src1_lrck  in  1  raw LRCK of source 1
src1_left  in  DW  left sample from source 1 receiver
src1_right  in  DW  right sample from source 1 receiver
src_en  in  2  per-source enable (bit n = source n)
out_valid  out  1  output sample pair valid
out_ready  in  1  downstream accepts sample pair
out_src  out  1  index of source of current output
out_left  out  DW  output left sample
out_right  out  DW  output right sample
ovr0  out  OVR_W  saturating overrun count, source 0
ovr1  out  OVR_W  saturating overrun count, source 1

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - reset is asynchronous and active-high; it clears all flops immediately.
  - Reset values: out_valid=0, out_src=0, out_left=0, out_right=0, ovr0=0, ovr1=0, all pending flags=0, RR pointer=0.
  - Synchronizer flops also reset to 0.
- Frame detect, per source:
  - Raw LRCK passes through a 2-FF synchronizer plus one delay flop.
  - frame_done = delayed & ~synced, i.e. a falling edge.
  - The right channel has completed at this point.
  - Capture occurs on the frame_done cycle, 3 clk after the raw fall first sampled.
  - srcN_left/right are treated as quasi-static and must be stable by then.
- Capture:
  - If frame_done and src_en[n]=1: hold_n <= {left,right}; pend_n <= 1.
  - If src_en[n]=0: no capture, pend_n is forced to 0, and the overrun counter is held.
- Overrun:
  - Occurs when frame_done on an enabled source coincides with pend_n=1 and source n is not popped that cycle.
  - Result: hold_n is overwritten with the newer frame and ovr_n is incremented, saturating at 2^OVR_W-1 with no wrap.
- Output stage:
  - Register slot is free when out_valid=0 or (out_valid & out_ready).
  - When free and any pend_n=1, load one source into out_* and set out_valid=1 in the same clock.
  - The popped pend_n clears unless a capture on that source occurs in the same cycle. Then the old hold_n goes out, the new frame is written, pend_n stays 1, and no overrun is counted.
  - When free and no source is pending, out_valid <= 0.
  - Throughput is 1 pair/clk when out_ready stays high.
- Arbitration:
  - Round-robin with a 1-bit pointer rr, naming the source preferred next.
  - Only one source pending: grant it.
  - Both pending: grant source rr.
  - After any grant of source g, rr <= ~g.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_src/out_left/out_right are held stable.
  - src_en changes do not retract a sample already in the output stage.
- Latency: capture to out_valid=1 is 1 clk when the output stage is free and there is no contention.
- Reset mid-transfer: the output is dropped, pending flags clear, and counters clear. Nothing is replayed.

Test Plan:
- Single source: src_en=01; src0 frame with L=0x1234, R=0xABCD; out_ready=1 -> out_valid pulses 1 clk with out_src=0, L=0x1234, R=0xABCD, 4 clk after raw LRCK fall.
- Contention: both sources' LRCK fall in the same clk, rr=0; src0 data 0x1111/0x2222, src1 data 0x3333/0x4444 -> src0 output first, src1 on the next clk, rr ends at 0.
- Backpressure: out_ready=0 for 10 clk while valid -> outputs stable throughout. src0 second frame arrives during the stall -> ovr0 stays 0. Third frame arrives -> ovr0=1 and the newest data is delivered after the in-flight pair.
- Saturation: OVR_W=2; 6 unconsumed src1 frames with out_ready=0 -> ovr1 reaches 3 and stays 3.
- Enable: src0 pending, then src_en[0] cleared -> pend0 cleared and no src0 output. Frames while disabled -> no output, ovr0 unchanged.
- Async reset asserted mid-stall with out_valid=1 -> out_valid=0 and counters=0 immediately without a clk edge. No output after release until a fresh LRCK fall.
